// File: rtl/ws2812_decoder.sv
// ws2812_decoder: single-wire WS2812 receiver. Synchronizes DIN, measures each
// high pulse to decode bits, assembles 24-bit GRB pixels and reports pixel
// strobes, frame latches and framing errors.
//
// Ports:
//   CLK          system clock
//   RST_N        synchronous active-low reset
//   DIN          asynchronous WS2812 data line
//   o_g/o_r/o_b  colour bytes of the last decoded pixel (held between strobes)
//   o_index      position of that pixel in the frame (saturates at 255)
//   o_valid      one-cycle strobe, pixel outputs updated
//   o_frame_end  one-cycle strobe, latch (long low) detected
//   o_error      one-cycle strobe, glitch, stuck-high or partial pixel
//   o_dout       forwarded data line (only with WS2812_DECODE_FORWARD_EN)
//
// Optional feature: define WS2812_DECODE_FORWARD_EN to forward the line after
// the first pixel of each frame; otherwise o_dout is tied low.
module ws2812_decoder #(
  parameter int unsigned BIT_THRESH   = 7,
  parameter int unsigned MIN_HIGH     = 2,
  parameter int unsigned HIGH_TIMEOUT = 24,
  parameter int unsigned LATCH_CYCLES = 600
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       DIN,
  output logic [7:0] o_g,
  output logic [7:0] o_r,
  output logic [7:0] o_b,
  output logic [7:0] o_index,
  output logic       o_valid,
  output logic       o_frame_end,
  output logic       o_error,
  output logic       o_dout
);

  localparam int unsigned HCW      = $clog2(HIGH_TIMEOUT + 1);
  localparam int unsigned LCW      = $clog2(LATCH_CYCLES + 1);
  localparam int unsigned BCW      = 5;
  localparam int unsigned PIX_BITS = 24;

  typedef enum logic [1:0] {S_SYNC, S_ARMED, S_HIGH, S_LOW} state_t;

  state_t         state, state_nxt;
  logic           din_s1, din_s2, din_d;
  logic           rise_q, fall_q;
  logic [HCW-1:0] hcnt, hcnt_nxt;
  logic [LCW-1:0] lcnt, lcnt_nxt;
  logic [BCW-1:0] bcnt, bcnt_nxt;
  logic [22:0]    shreg, shreg_nxt;
  logic [23:0]    shifted;
  logic [7:0]     pix_cnt, pix_cnt_nxt;
  logic [7:0]     g_nxt, r_nxt, b_nxt, idx_nxt;
  logic           valid_nxt, fe_nxt, err_nxt;

  // Two-flop synchronizer plus registered edge detect; din_d is aligned with rise_q/fall_q.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      din_s1 <= 1'b0;
      din_s2 <= 1'b0;
      din_d  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      din_s1 <= DIN;
      din_s2 <= din_s1;
      din_d  <= din_s2;
      rise_q <= din_s2 & ~din_d;
      fall_q <= ~din_s2 & din_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= S_SYNC;
      hcnt        <= '0;
      lcnt        <= '0;
      bcnt        <= '0;
      shreg       <= '0;
      pix_cnt     <= '0;
      o_g         <= '0;
      o_r         <= '0;
      o_b         <= '0;
      o_index     <= '0;
      o_valid     <= 1'b0;
      o_frame_end <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      state       <= state_nxt;
      hcnt        <= hcnt_nxt;
      lcnt        <= lcnt_nxt;
      bcnt        <= bcnt_nxt;
      shreg       <= shreg_nxt;
      pix_cnt     <= pix_cnt_nxt;
      o_g         <= g_nxt;
      o_r         <= r_nxt;
      o_b         <= b_nxt;
      o_index     <= idx_nxt;
      o_valid     <= valid_nxt;
      o_frame_end <= fe_nxt;
      o_error     <= err_nxt;
    end
  end

  // Next-state and datapath logic. hcnt holds (pulse width - 1) when the fall is seen.
  always_comb begin
    state_nxt   = state;
    hcnt_nxt    = hcnt;
    lcnt_nxt    = lcnt;
    bcnt_nxt    = bcnt;
    shreg_nxt   = shreg;
    pix_cnt_nxt = pix_cnt;
    g_nxt       = o_g;
    r_nxt       = o_r;
    b_nxt       = o_b;
    idx_nxt     = o_index;
    valid_nxt   = 1'b0;
    fe_nxt      = 1'b0;
    err_nxt     = 1'b0;
    shifted     = {shreg, (hcnt >= HCW'(BIT_THRESH - 1))};

    unique case (state)
      S_SYNC: begin
        if (din_d) begin
          lcnt_nxt = '0;
        end else if (lcnt == LCW'(LATCH_CYCLES - 1)) begin
          lcnt_nxt  = '0;
          state_nxt = S_ARMED;
        end else begin
          lcnt_nxt = lcnt + LCW'(1);
        end
      end

      S_ARMED: begin
        if (rise_q) begin
          hcnt_nxt  = '0;
          state_nxt = S_HIGH;
        end
      end

      S_HIGH: begin
        if (fall_q && (hcnt < HCW'(MIN_HIGH - 1))) begin
          // Glitch: drop the partial pixel and resynchronise on a full latch.
          err_nxt     = 1'b1;
          bcnt_nxt    = '0;
          pix_cnt_nxt = '0;
          lcnt_nxt    = '0;
          state_nxt   = S_SYNC;
        end else if (fall_q) begin
          shreg_nxt = shifted[22:0];
          lcnt_nxt  = '0;
          state_nxt = S_LOW;
          if (bcnt == BCW'(PIX_BITS - 1)) begin
            g_nxt     = shifted[23:16];
            r_nxt     = shifted[15:8];
            b_nxt     = shifted[7:0];
            idx_nxt   = pix_cnt;
            valid_nxt = 1'b1;
            bcnt_nxt  = '0;
            if (pix_cnt != 8'hFF) pix_cnt_nxt = pix_cnt + 8'd1;
          end else begin
            bcnt_nxt = bcnt + BCW'(1);
          end
        end else if (hcnt == HCW'(HIGH_TIMEOUT - 1)) begin
          // Stuck high: same recovery as a glitch.
          err_nxt     = 1'b1;
          bcnt_nxt    = '0;
          pix_cnt_nxt = '0;
          lcnt_nxt    = '0;
          state_nxt   = S_SYNC;
        end else begin
          hcnt_nxt = hcnt + HCW'(1);
        end
      end

      S_LOW: begin
        if (rise_q) begin
          hcnt_nxt  = '0;
          state_nxt = S_HIGH;
        end else if (lcnt == LCW'(LATCH_CYCLES - 1)) begin
          // Latch: end of frame; leftover bits mean a truncated pixel.
          fe_nxt      = 1'b1;
          err_nxt     = (bcnt != '0);
          bcnt_nxt    = '0;
          pix_cnt_nxt = '0;
          state_nxt   = S_ARMED;
        end else begin
          lcnt_nxt = lcnt + LCW'(1);
        end
      end

      default: state_nxt = S_SYNC;
    endcase
  end

`ifdef WS2812_DECODE_FORWARD_EN
  logic fwd_en;

  // Forward once the first pixel of the frame has been absorbed; drop at latch or error.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      fwd_en <= 1'b0;
      o_dout <= 1'b0;
    end else begin
      o_dout <= fwd_en & din_s2;
      if (fe_nxt || err_nxt) fwd_en <= 1'b0;
      else if (valid_nxt)    fwd_en <= 1'b1;
    end
  end
`else
  assign o_dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_decoder.sv
// Self-checking bench for ws2812_decoder: randomized pixel streams against a
// stream-level model of expected strobes, indices and errors.
module tb_ws2812_decoder;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       DIN = 1'b0;
  logic [7:0] o_g, o_r, o_b, o_index;
  logic       o_valid, o_frame_end, o_error, o_dout;

  ws2812_decoder dut (
    .CLK(CLK), .RST_N(RST_N), .DIN(DIN),
    .o_g(o_g), .o_r(o_r), .o_b(o_b), .o_index(o_index),
    .o_valid(o_valid), .o_frame_end(o_frame_end), .o_error(o_error),
    .o_dout(o_dout)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Observations captured on the falling edge.
  int          cyc = 0;
  int          last_fall = 0;
  logic        din_prev = 1'b0;
  logic [31:0] obs_px[$];
  int          obs_lat[$];
  int          fe_cnt, err_cnt, both_cnt, vf_cnt, dout_hi;
  bit          rec_en = 1'b0;
  bit          din_h[$];
  bit          dout_h[$];

  // Reference model state: expected pixel stream {index, g, r, b} and event counts.
  logic [31:0] exp_px[$];
  int          model_idx = 0;
  int          exp_fe, exp_err, exp_both;

  always @(negedge CLK) begin
    cyc++;
    if (din_prev && !DIN) last_fall = cyc;
    din_prev = DIN;
    if (o_valid) begin
      obs_px.push_back({o_index, o_g, o_r, o_b});
      obs_lat.push_back(cyc - last_fall);
    end
    if (o_frame_end) fe_cnt++;
    if (o_error) err_cnt++;
    if (o_error && o_frame_end) both_cnt++;
    if (o_valid && o_frame_end) vf_cnt++;
    if (o_dout) dout_hi++;
    if (rec_en) begin
      din_h.push_back(DIN);
      dout_h.push_back(o_dout);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic clear_obs();
    obs_px.delete();
    obs_lat.delete();
    exp_px.delete();
    fe_cnt = 0; err_cnt = 0; both_cnt = 0; vf_cnt = 0;
    exp_fe = 0; exp_err = 0; exp_both = 0;
  endtask

  task automatic send_bit(input int hi, input int lo);
    DIN = 1'b1;
    tick(hi);
    DIN = 1'b0;
    tick(lo);
  endtask

  // mode 0: 4/11 and 8/7 encodings; 1: random legal widths; 2: tightest legal widths.
  task automatic bit_timing(input bit b, input int mode, output int hi, output int lo);
    case (mode)
      0:       begin hi = b ? 8 : 4; lo = b ? 7 : 11; end
      1:       begin hi = b ? int'($urandom_range(24, 7)) : int'($urandom_range(6, 2));
                     lo = int'($urandom_range(12, 3)); end
      default: begin hi = b ? 7 : 2; lo = 3; end
    endcase
  endtask

  task automatic send_pixel(input logic [23:0] grb, input int mode);
    int hi, lo;
    for (int i = 23; i >= 0; i--) begin
      bit_timing(grb[i], mode, hi, lo);
      send_bit(hi, lo);
    end
    exp_px.push_back({8'(model_idx), grb});
    if (model_idx < 255) model_idx++;
  endtask

  task automatic send_bits(input int n);
    int hi, lo;
    for (int i = 0; i < n; i++) begin
      bit_timing(1'($urandom), 0, hi, lo);
      send_bit(hi, lo);
    end
  endtask

  task automatic latch();
    DIN = 1'b0;
    tick(650);
    model_idx = 0;
    exp_fe++;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    tick(3);
    vectors++;
    if ({o_g, o_r, o_b, o_index, o_valid, o_frame_end, o_error, o_dout} !== 36'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0",
               {o_g, o_r, o_b, o_index, o_valid, o_frame_end, o_error, o_dout});
    end
    RST_N = 1'b1;
    tick(2);
    vectors++;
    if ({o_valid, o_frame_end, o_error} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b expected 000", {o_valid, o_frame_end, o_error});
    end
  endtask

  task automatic test_single();
    clear_obs();
    tick(600);
    send_pixel(24'h40_00_00, 0);
    latch();
    vectors++;
    if (obs_px.size() != 1 || obs_px[0] !== 32'h00_40_00_00) begin
      miscompares++;
      $display("FAIL single_pixel: got %0d strobes first %h expected 1 strobe 00400000",
               obs_px.size(), (obs_px.size() > 0) ? obs_px[0] : 32'hx);
    end
    vectors++;
    if (obs_lat.size() > 0 && obs_lat[0] != 4) begin
      miscompares++;
      $display("FAIL single_latency: got %0d expected 4", obs_lat[0]);
    end
    vectors++;
    if (fe_cnt != 1 || err_cnt != 0) begin
      miscompares++;
      $display("FAIL single_events: got fe=%0d err=%0d expected fe=1 err=0", fe_cnt, err_cnt);
    end
  endtask

  task automatic test_frames();
    logic [7:0] bvals[10] = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    clear_obs();
    foreach (bvals[i]) send_pixel({16'($urandom), bvals[i]}, 0);
    latch();
    for (int i = 0; i < 5; i++) send_pixel(24'($urandom), 1);
    latch();
    vectors++;
    if (obs_px.size() != exp_px.size()) begin
      miscompares++;
      $display("FAIL frames_count: got %0d expected %0d", obs_px.size(), exp_px.size());
    end
    foreach (exp_px[i]) if (i < obs_px.size()) begin
      vectors++;
      if (obs_px[i] !== exp_px[i]) begin
        miscompares++;
        $display("FAIL frames_pixel%0d: got %h expected %h", i, obs_px[i], exp_px[i]);
      end
      vectors++;
      if (obs_lat[i] != 4) begin
        miscompares++;
        $display("FAIL frames_latency%0d: got %0d expected 4", i, obs_lat[i]);
      end
    end
    vectors++;
    if (fe_cnt != exp_fe || err_cnt != exp_err || vf_cnt != 0) begin
      miscompares++;
      $display("FAIL frames_events: got fe=%0d err=%0d vf=%0d expected fe=%0d err=%0d vf=0",
               fe_cnt, err_cnt, vf_cnt, exp_fe, exp_err);
    end
  endtask

  task automatic test_random();
    clear_obs();
    for (int f = 0; f < 3; f++) begin
      int n = int'($urandom_range(6, 1));
      for (int p = 0; p < n; p++) send_pixel(24'($urandom), int'($urandom_range(2, 1)));
      latch();
    end
    vectors++;
    if (obs_px.size() != exp_px.size()) begin
      miscompares++;
      $display("FAIL random_count: got %0d expected %0d", obs_px.size(), exp_px.size());
    end
    foreach (exp_px[i]) if (i < obs_px.size()) begin
      vectors++;
      if (obs_px[i] !== exp_px[i] || obs_lat[i] != 4) begin
        miscompares++;
        $display("FAIL random_pixel%0d: got %h lat %0d expected %h lat 4",
                 i, obs_px[i], obs_lat[i], exp_px[i]);
      end
    end
    vectors++;
    if (fe_cnt != exp_fe || err_cnt != 0) begin
      miscompares++;
      $display("FAIL random_events: got fe=%0d err=%0d expected fe=%0d err=0", fe_cnt, err_cnt, exp_fe);
    end
  endtask

  task automatic test_stuck_high();
    clear_obs();
    send_bits(10);
    DIN = 1'b1;
    tick(30);
    DIN = 1'b0;
    exp_err++;
    model_idx = 0;
    tick(650);
    vectors++;
    if (obs_px.size() != 0 || err_cnt != 1 || fe_cnt != 0) begin
      miscompares++;
      $display("FAIL stuck_recovery: got valid=%0d err=%0d fe=%0d expected 0/1/0",
               obs_px.size(), err_cnt, fe_cnt);
    end
    send_pixel(24'($urandom), 1);
    latch();
    vectors++;
    if (obs_px.size() != 1 || obs_px[0] !== exp_px[0]) begin
      miscompares++;
      $display("FAIL stuck_pixel: got %0d strobes first %h expected 1 strobe %h",
               obs_px.size(), (obs_px.size() > 0) ? obs_px[0] : 32'hx, exp_px[0]);
    end
    vectors++;
    if (err_cnt != exp_err || fe_cnt != exp_fe) begin
      miscompares++;
      $display("FAIL stuck_events: got err=%0d fe=%0d expected err=%0d fe=%0d",
               err_cnt, fe_cnt, exp_err, exp_fe);
    end
  endtask

  task automatic test_partial_glitch();
    clear_obs();
    send_bits(12);
    latch();
    exp_err++;
    exp_both++;
    vectors++;
    if (obs_px.size() != 0 || err_cnt != exp_err || fe_cnt != exp_fe || both_cnt != exp_both) begin
      miscompares++;
      $display("FAIL partial_latch: got valid=%0d err=%0d fe=%0d both=%0d expected 0/%0d/%0d/%0d",
               obs_px.size(), err_cnt, fe_cnt, both_cnt, exp_err, exp_fe, exp_both);
    end
    DIN = 1'b1;
    tick(1);
    DIN = 1'b0;
    exp_err++;
    model_idx = 0;
    tick(650);
    vectors++;
    if (err_cnt != exp_err || fe_cnt != exp_fe) begin
      miscompares++;
      $display("FAIL glitch_error: got err=%0d fe=%0d expected err=%0d fe=%0d",
               err_cnt, fe_cnt, exp_err, exp_fe);
    end
    send_pixel(24'($urandom), 0);
    latch();
    vectors++;
    if (obs_px.size() != 1 || obs_px[0] !== exp_px[0] || fe_cnt != exp_fe) begin
      miscompares++;
      $display("FAIL glitch_resync: got %0d strobes first %h fe=%0d expected 1 strobe %h fe=%0d",
               obs_px.size(), (obs_px.size() > 0) ? obs_px[0] : 32'hx, fe_cnt, exp_px[0], exp_fe);
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    send_bits(10);
    RST_N = 1'b0;
    tick(1);
    vectors++;
    if ({o_g, o_r, o_b, o_index, o_valid, o_frame_end, o_error, o_dout} !== 36'h0) begin
      miscompares++;
      $display("FAIL resetmid_outputs: got %h expected 0",
               {o_g, o_r, o_b, o_index, o_valid, o_frame_end, o_error, o_dout});
    end
    RST_N = 1'b1;
    model_idx = 0;
    tick(650);
    vectors++;
    if (obs_px.size() != 0 || err_cnt != 0 || fe_cnt != 0) begin
      miscompares++;
      $display("FAIL resetmid_quiet: got valid=%0d err=%0d fe=%0d expected 0/0/0",
               obs_px.size(), err_cnt, fe_cnt);
    end
    send_pixel(24'($urandom), 0);
    latch();
    vectors++;
    if (obs_px.size() != 1 || obs_px[0] !== exp_px[0] || fe_cnt != 1 || err_cnt != 0) begin
      miscompares++;
      $display("FAIL resetmid_pixel: got %0d strobes first %h fe=%0d err=%0d expected 1 strobe %h fe=1 err=0",
               obs_px.size(), (obs_px.size() > 0) ? obs_px[0] : 32'hx, fe_cnt, err_cnt, exp_px[0]);
    end
  endtask

  task automatic test_forward();
    int p1;
    bit exp_d;
    int bad = 0;
    clear_obs();
    din_h.delete();
    dout_h.delete();
    rec_en = 1'b1;
    send_pixel(24'($urandom), 0);
    p1 = din_h.size();
    send_pixel(24'($urandom), 1);
    tick(10);
    rec_en = 1'b0;
    latch();
    foreach (dout_h[t]) begin
`ifdef WS2812_DECODE_FORWARD_EN
      exp_d = (t >= p1 + 3) ? din_h[t - 3] : 1'b0;
`else
      exp_d = 1'b0;
`endif
      vectors++;
      if (dout_h[t] !== exp_d) begin
        miscompares++;
        bad++;
        if (bad <= 8) $display("FAIL forward_dout@%0d: got %b expected %b", t, dout_h[t], exp_d);
      end
    end
    vectors++;
    if (obs_px.size() != 2 || obs_px[0] !== exp_px[0] || obs_px[1] !== exp_px[1]) begin
      miscompares++;
      $display("FAIL forward_pixels: got %0d strobes expected 2 (%h %h)",
               obs_px.size(), exp_px[0], exp_px[1]);
    end
  endtask

  task automatic test_saturation();
    clear_obs();
    for (int i = 0; i < 255; i++) send_pixel(24'h0, 2);
    send_pixel(24'($urandom), 2);
    send_pixel(24'($urandom), 2);
    latch();
    vectors++;
    if (obs_px.size() != exp_px.size()) begin
      miscompares++;
      $display("FAIL sat_count: got %0d expected %0d", obs_px.size(), exp_px.size());
    end
    foreach (exp_px[i]) if (i < obs_px.size()) begin
      vectors++;
      if (obs_px[i] !== exp_px[i]) begin
        miscompares++;
        $display("FAIL sat_pixel%0d: got %h expected %h", i, obs_px[i], exp_px[i]);
      end
    end
    vectors++;
    if (fe_cnt != 1 || err_cnt != 0 || vf_cnt != 0) begin
      miscompares++;
      $display("FAIL sat_events: got fe=%0d err=%0d vf=%0d expected 1/0/0", fe_cnt, err_cnt, vf_cnt);
    end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_single();
    test_frames();
    test_random();
    test_stuck_high();
    test_partial_glitch();
    test_reset_mid();
    test_forward();
    test_saturation();
`ifndef WS2812_DECODE_FORWARD_EN
    vectors++;
    if (dout_hi != 0) begin
      miscompares++;
      $display("FAIL dout_tied: got %0d high cycles expected 0", dout_hi);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ws2812_decoder.md
# ws2812_decoder

Receive-side counterpart of the NeoPixel bit writer. It samples a single-wire WS2812 data line and measures each high pulse to decode bits. It assembles 24-bit GRB pixels and presents each one with a one-cycle valid strobe, a pixel index and frame-latch detection. It sits at a PMOD input pin and is used to loop back our own LED output for self-test, or to accept pixel streams from an upstream controller.

## Interface
Parameters:
- `BIT_THRESH`, 7: high-pulse width, in cycles, at or above which a bit decodes as 1 (0.58 µs at 12 MHz).
- `MIN_HIGH`, 2: high pulses shorter than this are glitches.
- `HIGH_TIMEOUT`, 24: a high pulse longer than this is an error.
- `LATCH_CYCLES`, 600: low time that ends a frame (50 µs at 12 MHz).

Ports (all synchronous to `CLK`; reset is synchronous and active-low):
- `CLK`  in  1  system clock.
- `RST_N`  in  1  synchronous active-low reset.
- `DIN`  in  1  asynchronous WS2812 data line.
- `o_g`  out  8  green byte of the last pixel.
- `o_r`  out  8  red byte of the last pixel.
- `o_b`  out  8  blue byte of the last pixel.
- `o_index`  out  8  position of the pixel within the frame, starting at 0.
- `o_valid`  out  1  one-cycle strobe; pixel outputs are valid.
- `o_frame_end`  out  1  one-cycle strobe; latch detected.
- `o_error`  out  1  one-cycle strobe; timeout, glitch or partial pixel.
- `o_dout`  out  1  forwarded data line; see Configuration.

## Operation
- `DIN` passes through a 2-FF synchronizer. Edges are detected on the synchronized signal by comparing it with its registered copy.
- States:
  - **SYNC** (entered at reset): waits for `LATCH_CYCLES` consecutive low cycles, then moves to ARMED. No `o_frame_end` is emitted on this exit.
  - **ARMED**: waits for a rising edge, then clears the high counter and moves to HIGH.
  - **HIGH**: counts high cycles.
    - Falling edge with count < `MIN_HIGH`: glitch. Pulse `o_error`, discard the partial pixel, go to SYNC.
    - Falling edge otherwise: the bit is (count ≥ `BIT_THRESH`). Shift it MSB-first into the 24-bit shift register, increment the bit counter, then go to LOW.
    - Count reaches `HIGH_TIMEOUT`: pulse `o_error`, go to SYNC.
  - **LOW**: counts low cycles; the counter saturates.
    - Rising edge: go to HIGH.
    - Count reaches `LATCH_CYCLES`: go to ARMED.
- Bit order is G[7:0], then R[7:0], then B[7:0], each MSB first.
- On the 24th bit:
  - Load `o_g`/`o_r`/`o_b` from the shift register and pulse `o_valid`.
  - `o_index` is driven with the current pixel count, which then increments. The count saturates at 255; `o_valid` keeps firing with `o_index`=255.
  - The bit counter resets to 0.
- Latch (LOW count reaches `LATCH_CYCLES`):
  - Pulse `o_frame_end` and reset the pixel count to 0.
  - If the bit counter is 1–23, also pulse `o_error` in the same cycle and discard those bits.
- `o_g`/`o_r`/`o_b`/`o_index` hold their values between `o_valid` strobes.
- Reset: all outputs 0, all counters 0, state SYNC. A reset mid-pixel discards the partial data, with no strobes.

## Timing
- A `DIN` edge reaches the synchronized signal 2 cycles later. Edge detection adds 1 more cycle.
- `o_valid` is asserted in the cycle after the cycle in which the 24th falling edge is detected, i.e. 4 cycles after the raw `DIN` fall.
- `o_frame_end` is asserted in the cycle after the LOW count reaches `LATCH_CYCLES`, once per low period.
- `o_valid` and `o_frame_end` can never coincide: a valid strobe precedes a latch by at least `LATCH_CYCLES`.
- Back-to-back bits need only `MIN_HIGH` + 1 low cycle; there is no throughput limit below the WS2812 rate.
- Strobes are single-cycle and have no back-pressure. Consumers must capture them on the strobe cycle.

## Configuration
- `WS2812_DECODE_FORWARD_EN` defined:
  - `o_dout` follows the synchronized `DIN`, delayed 1 cycle, once the first pixel of the frame has been decoded. This mimics a chained WS2812 that absorbs its first 24 bits.
  - Before that point `o_dout` is 0; it returns to 0 at each latch.
  - A 24th falling edge is forwarded, with the forward enable taking effect at the next rising edge.
- `WS2812_DECODE_FORWARD_EN` undefined: `o_dout` is tied to 0 and the forwarding logic is absent.

## Test plan
- **Single pixel:** reset, hold `DIN` low for 600 cycles, then send G=0x40, R=0x00, B=0x00. Encode a 0 as 4 high + 11 low cycles and a 1 as 8 high + 7 low. Then hold low for 600 cycles.
  - Required: one `o_valid` with `o_g`=0x40, `o_r`=0x00, `o_b`=0x00, `o_index`=0, then one `o_frame_end`.
- **Ten-pixel frame:** send ten pixels with B values 0x00,0x00,0x00,0x02,0x04,0x08,0x10,0x20,0x40,0x80, then latch, then a second frame.
  - Required: ten `o_valid` strobes with `o_index` 0–9 and the matching `o_b` values; the second frame restarts at index 0.
- **Stuck high:** hold `DIN` high for 30 cycles mid-pixel.
  - Required: `o_error` pulses once; no `o_valid` occurs until after a 600-cycle low; the next pixel decodes correctly with `o_index`=0.
- **Partial pixel and glitch:**
  - Send 12 bits, then latch. Required: `o_error` and `o_frame_end` pulse in the same cycle, with no `o_valid`.
  - Send a 1-cycle high glitch. Required: `o_error` pulses and the block resynchronises.
- **Reset mid-pixel:** assert `RST_N`=0 for 1 cycle after 10 bits.
  - Required: all outputs are 0, with no strobes until a 600-cycle low, followed by a full pixel.
- **Forwarding, with `WS2812_DECODE_FORWARD_EN` defined:** send two pixels.
  - Required: `o_dout` is 0 during pixel 0, then reproduces pixel 1's waveform with a 3-cycle delay from `DIN`.
  - Without the macro, `o_dout` is constantly 0.
